// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma engine: FSM states, error codes
// and command modes.
package mem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma_if.sv
// Block-memory request/response port. The DMA engine is the master and
// drives the request side; the memory responder is the slave.
interface mem_dma_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_en;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_bsel;
  logic                wr_en;
  logic                wr_ack;

  modport master (
    output rd_addr, rd_en, wr_addr, wr_data, wr_bsel, wr_en,
    input  rd_data, rd_valid, wr_ack
  );

  modport slave (
    input  rd_addr, rd_en, wr_addr, wr_data, wr_bsel, wr_en,
    output rd_data, rd_valid, wr_ack
  );

endinterface

// File: rtl/mem_dma_watchdog.sv
// Cycle counter that measures how long a memory request has been waiting.
// clear reloads zero, enable counts one waiting cycle, and expired flags the
// cycle in which the TIMEOUT-th consecutive waiting cycle is being spent.
// TIMEOUT = 0 disables the watchdog entirely.
module mem_dma_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, arst_n, clear, enable};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
      logic [CNT_W-1:0] count;

      // Count waiting cycles, stopping at the limit so the count cannot wrap
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable && !expired) begin
          count <= count + 1'b1;
        end
      end

      assign expired = (count == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_dma.sv
// Initiator-side DMA engine for the block-memory port. Executes one command
// at a time: copy LEN words from SRC to DST, or fill LEN words at DST with a
// constant. Every output is registered; request signals are held stable until
// the matching response is sampled.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_mode,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   cmd_fill,
  input  logic [DATA_W/8-1:0] cmd_bsel,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [LEN_W-1:0]    words_done,
  mem_dma_if.master           mem
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                mode_q, mode_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W/8-1:0] wr_bsel_q, wr_bsel_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [LEN_W-1:0]    words_done_q, words_done_d;

  logic                halt;
  logic [1:0]          halt_code;
  logic                wd_waiting;
  logic                wd_expired;

  // A request is waiting whenever its enable is up and no response arrived
  assign wd_waiting = ((state_q == RD) && !mem.rd_valid) ||
                      ((state_q == WR) && !mem.wr_ack);

  mem_dma_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .arst_n  (arst_n),
    .clear   (!wd_waiting),
    .enable  (wd_waiting),
    .expired (wd_expired)
  );

  // Next-state and registered-output computation; responses take priority
  // over abort, and abort over timeout
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    mode_d       = mode_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    wr_data_d    = wr_data_q;
    wr_bsel_d    = wr_bsel_q;
    busy_d       = busy_q;
    cmd_ready_d  = cmd_ready_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    err_code_d   = err_code_q;
    words_done_d = words_done_q;
    halt         = 1'b0;
    halt_code    = ERR_NONE;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          src_d        = cmd_src;
          dst_d        = cmd_dst;
          len_d        = cmd_len;
          mode_d       = cmd_mode;
          words_done_d = '0;
          err_code_d   = ERR_NONE;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d      = 1'b1;
            cmd_ready_d = 1'b0;
            if (cmd_mode == MODE_COPY) begin
              rd_en_d = 1'b1;
              state_d = RD;
            end else begin
              wr_en_d   = 1'b1;
              wr_data_d = cmd_fill;
              wr_bsel_d = cmd_bsel;
              state_d   = WR;
            end
          end
        end
      end

      RD: begin
        if (mem.rd_valid && !abort) begin
          rd_en_d   = 1'b0;
          wr_en_d   = 1'b1;
          wr_data_d = mem.rd_data;
          wr_bsel_d = '1;
          state_d   = WR;
        end else if (abort) begin
          halt      = 1'b1;
          halt_code = ERR_ABORT;
        end else if (wd_expired) begin
          halt      = 1'b1;
          halt_code = ERR_TIMEOUT;
        end
      end

      WR: begin
        if (mem.wr_ack) begin
          words_done_d = words_done_q + 1'b1;
          src_d        = src_q + 1'b1;
          dst_d        = dst_q + 1'b1;
          if (words_done_d == len_q) begin
            wr_en_d     = 1'b0;
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else if (abort) begin
            halt      = 1'b1;
            halt_code = ERR_ABORT;
          end else if (mode_q == MODE_COPY) begin
            wr_en_d = 1'b0;
            rd_en_d = 1'b1;
            state_d = RD;
          end
        end else if (abort) begin
          halt      = 1'b1;
          halt_code = ERR_ABORT;
        end else if (wd_expired) begin
          halt      = 1'b1;
          halt_code = ERR_TIMEOUT;
        end
      end

      default: state_d = IDLE;
    endcase

    if (halt) begin
      state_d     = IDLE;
      rd_en_d     = 1'b0;
      wr_en_d     = 1'b0;
      busy_d      = 1'b0;
      cmd_ready_d = 1'b1;
      error_d     = 1'b1;
      err_code_d  = halt_code;
    end
  end

  // State and output registers, all cleared by reset except cmd_ready
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      mode_q       <= MODE_COPY;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_bsel_q    <= '0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_bsel_q    <= wr_bsel_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      words_done_q <= words_done_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign words_done  = words_done_q;
  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = src_q;
  assign mem.wr_en   = wr_en_q;
  assign mem.wr_addr = dst_q;
  assign mem.wr_data = wr_data_q;
  assign mem.wr_bsel = wr_bsel_q;

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: a latency-configurable memory stub with a write
// scoreboard, plus directed copy, fill, zero-length, timeout, abort and
// address-wrap scenarios.
module tb_mem_dma;
  import mem_dma_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bsel;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_mode;
  logic [31:0] cmd_src;
  logic [31:0] cmd_dst;
  logic [15:0] cmd_len;
  logic [31:0] cmd_fill;
  logic [3:0]  cmd_bsel;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_done;

  mem_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_dma #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .cmd_fill   (cmd_fill),
    .cmd_bsel   (cmd_bsel),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .words_done (words_done),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];
  wr_exp_t     sb_q [$];

  int rd_wait = 0, rd_lat = 2, wr_wait = 0, wr_lat = 1;
  bit rd_resp = 0, wr_resp = 0;
  bit rand_lat = 0, no_ack = 0, spur_en = 0;
  int abort_at = 0;
  int reads = 0, writes = 0;
  int done_cnt = 0, err_cnt = 0, rd_cycles = 0, wr_cycles = 0, busy_cycles = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic int pickLat(input int fixed_lat);
    return rand_lat ? int'($urandom_range(0, 6)) : fixed_lat;
  endfunction

  // Memory responder: answers each request after its latency, commits writes
  // with byte masking, checks them against the scoreboard, and optionally
  // injects spurious responses and a same-cycle abort
  always @(negedge clk) begin : stub
    wr_exp_t     e;
    logic [31:0] merged;
    abort = 1'b0;

    if (rd_resp) begin
      rd_resp = 0; rd_wait = 0; rd_lat = pickLat(2);
    end
    bus.rd_valid = 1'b0;
    if (bus.rd_en) begin
      if (rd_wait == rd_lat) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = memRead(bus.rd_addr);
        rd_resp = 1;
        reads++;
      end else begin
        rd_wait++;
      end
    end else begin
      rd_wait = 0;
      if (spur_en && $urandom_range(0, 1) == 1) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = $urandom;
      end
    end

    if (wr_resp) begin
      wr_resp = 0; wr_wait = 0; wr_lat = pickLat(1);
    end
    bus.wr_ack = 1'b0;
    if (bus.wr_en) begin
      if (!no_ack && wr_wait == wr_lat) begin
        bus.wr_ack = 1'b1;
        wr_resp = 1;
        writes++;
        merged = memRead(bus.wr_addr);
        for (int b = 0; b < 4; b++)
          if (bus.wr_bsel[b]) merged[8*b +: 8] = bus.wr_data[8*b +: 8];
        mem[bus.wr_addr] = merged;
        if (sb_q.size() == 0) begin
          checkOutput("sb_extra_write", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_wr_addr", 64'(bus.wr_addr), 64'(e.addr));
          checkOutput("sb_wr_data", 64'(bus.wr_data), 64'(e.data));
          checkOutput("sb_wr_bsel", 64'(bus.wr_bsel), 64'(e.bsel));
        end
        if (abort_at != 0 && writes == abort_at) abort = 1'b1;
      end else begin
        wr_wait++;
      end
    end else begin
      wr_wait = 0;
      if (spur_en && $urandom_range(0, 1) == 1) bus.wr_ack = 1'b1;
    end
  end

  // Activity monitor counting status pulses and enable cycles
  always @(negedge clk) begin
    if (done)       done_cnt++;
    if (error)      err_cnt++;
    if (bus.rd_en)  rd_cycles++;
    if (bus.wr_en)  wr_cycles++;
    if (busy)       busy_cycles++;
  end

  task automatic clearMon();
    done_cnt = 0; err_cnt = 0; rd_cycles = 0; wr_cycles = 0; busy_cycles = 0;
    reads = 0; writes = 0;
  endtask

  task automatic applyStimulus(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] len, input logic [31:0] fill, input logic [3:0] bsel);
    @(negedge clk);
    cmd_mode = mode; cmd_src = src; cmd_dst = dst;
    cmd_len = len; cmd_fill = fill; cmd_bsel = bsel;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitEnd(input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin
        seen = 1;
        break;
      end
    end
    checkOutput(tag, 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : global_guard
    #500000;
    $display("[TB] FAIL global_guard: simulation did not finish in time");
    $fatal(1, "[TB] global guard expired");
  end

  initial begin : main
    logic [31:0] vals [4];
    int k;

    cmd_valid = 0; cmd_mode = 0; cmd_src = 0; cmd_dst = 0;
    cmd_len = 0; cmd_fill = 0; cmd_bsel = 0;
    for (int i = 0; i < 4; i++) mem[32'h10 + i] = 32'h0000_00A0 + i;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_status", 64'({busy, done, error, err_code}), 64'd0);
    checkOutput("rst_words_done", 64'(words_done), 64'd0);
    checkOutput("rst_enables", 64'({bus.rd_en, bus.wr_en}), 64'd0);
    checkOutput("rst_addrs", 64'({bus.rd_addr, bus.wr_addr}), 64'd0);
    checkOutput("rst_wdata", 64'({bus.wr_data, bus.wr_bsel}), 64'd0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Copy 4 words 0x10 -> 0x40
    $display("[TB] copy len=4");
    clearMon();
    for (int i = 0; i < 4; i++) sb_q.push_back('{32'h40 + i, 32'h0000_00A0 + i, 4'hF});
    applyStimulus(MODE_COPY, 32'h10, 32'h40, 16'd4, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("copy_t1_busy", 64'({busy, cmd_ready}), 64'b10);
    checkOutput("copy_t1_rd", 64'({bus.rd_en, bus.wr_en}), 64'b10);
    checkOutput("copy_t1_rd_addr", 64'(bus.rd_addr), 64'h10);
    waitEnd(100, "copy_end_seen");
    checkOutput("copy_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("copy_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("copy_words_done", 64'(words_done), 64'd4);
    checkOutput("copy_reads", 64'(reads), 64'd4);
    checkOutput("copy_writes", 64'(writes), 64'd4);
    checkOutput("copy_mem_43", 64'(memRead(32'h43)), 64'h0000_00A3);
    checkOutput("copy_idle", 64'({busy, cmd_ready, err_code}), 64'b0100);

    // Fill 3 words at 0x80 with partial byte select
    $display("[TB] fill len=3");
    clearMon();
    for (int i = 0; i < 3; i++) sb_q.push_back('{32'h80 + i, 32'hDEAD_BEEF, 4'h5});
    applyStimulus(MODE_FILL, 32'h0, 32'h80, 16'd3, 32'hDEAD_BEEF, 4'h5);
    @(negedge clk);
    checkOutput("fill_t1_en", 64'({bus.rd_en, bus.wr_en}), 64'b01);
    checkOutput("fill_t1_wr", 64'({bus.wr_addr, bus.wr_data}), {32'h80, 32'hDEAD_BEEF});
    checkOutput("fill_t1_bsel", 64'(bus.wr_bsel), 64'h5);
    waitEnd(100, "fill_end_seen");
    checkOutput("fill_rd_cycles", 64'(rd_cycles), 64'd0);
    checkOutput("fill_writes", 64'(writes), 64'd3);
    checkOutput("fill_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("fill_words_done", 64'(words_done), 64'd3);
    checkOutput("fill_mem_80", 64'(memRead(32'h80)), 64'h00AD_00EF);

    // Zero-length command
    $display("[TB] len=0");
    clearMon();
    applyStimulus(MODE_COPY, 32'h10, 32'h90, 16'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("len0_t1", 64'({done, busy, cmd_ready}), 64'b101);
    checkOutput("len0_words_done", 64'(words_done), 64'd0);
    repeat (4) @(negedge clk);
    checkOutput("len0_no_traffic", 64'(rd_cycles + wr_cycles + busy_cycles), 64'd0);
    checkOutput("len0_done_cnt", 64'(done_cnt), 64'd1);

    // Write never acknowledged
    $display("[TB] timeout");
    clearMon();
    no_ack = 1;
    applyStimulus(MODE_FILL, 32'h0, 32'h100, 16'd2, 32'h1234, 4'hF);
    @(negedge clk);
    checkOutput("to_t1_wr_en", 64'(bus.wr_en), 64'd1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (error) begin
        k = i;
        break;
      end
    end
    checkOutput("to_latency", 64'(k), 64'd8);
    checkOutput("to_err_code", 64'(err_code), 64'(ERR_TIMEOUT));
    checkOutput("to_state", 64'({bus.wr_en, busy, cmd_ready}), 64'b001);
    checkOutput("to_words_done", 64'(words_done), 64'd0);
    @(negedge clk);
    checkOutput("to_err_pulse", 64'({error, err_code}), 64'({1'b0, ERR_TIMEOUT}));
    no_ack = 0;
    repeat (2) @(negedge clk);

    // Abort coinciding with the third write acknowledge
    $display("[TB] abort");
    clearMon();
    for (int i = 0; i < 5; i++) mem[32'h200 + i] = 32'hC0DE_0000 + i;
    mem[32'h303] = 32'h5555_5555;
    for (int i = 0; i < 3; i++) sb_q.push_back('{32'h300 + i, 32'hC0DE_0000 + i, 4'hF});
    abort_at = 3;
    applyStimulus(MODE_COPY, 32'h200, 32'h300, 16'd5, 32'h0, 4'h0);
    waitEnd(100, "abort_end_seen");
    abort_at = 0;
    checkOutput("abort_err_cnt", 64'(err_cnt), 64'd1);
    checkOutput("abort_done_cnt", 64'(done_cnt), 64'd0);
    checkOutput("abort_err_code", 64'(err_code), 64'(ERR_ABORT));
    checkOutput("abort_words_done", 64'(words_done), 64'd3);
    checkOutput("abort_writes", 64'(writes), 64'd3);
    checkOutput("abort_mem_303", 64'(memRead(32'h303)), 64'h5555_5555);
    clearMon();
    for (int i = 0; i < 2; i++) sb_q.push_back('{32'h500 + i, 32'h0000_00A0 + i, 4'hF});
    applyStimulus(MODE_COPY, 32'h10, 32'h500, 16'd2, 32'h0, 4'h0);
    waitEnd(100, "post_abort_end_seen");
    checkOutput("post_abort_done", 64'(done_cnt), 64'd1);
    checkOutput("post_abort_status", 64'({err_code, words_done}), 64'({ERR_NONE, 16'd2}));

    // Random latencies, spurious responses, destination wrap
    $display("[TB] random latency and wrap");
    rand_lat = 1;
    spur_en = 1;
    clearMon();
    repeat (20) @(negedge clk);
    checkOutput("spur_idle_quiet", 64'(busy_cycles + done_cnt + err_cnt), 64'd0);
    checkOutput("spur_words_done", 64'(words_done), 64'd2);
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      mem[32'h600 + i] = vals[i];
      sb_q.push_back('{32'hFFFF_FFFE + i, vals[i], 4'hF});
    end
    clearMon();
    applyStimulus(MODE_COPY, 32'h600, 32'hFFFF_FFFE, 16'd4, 32'h0, 4'h0);
    waitEnd(300, "wrap_end_seen");
    checkOutput("wrap_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("wrap_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("wrap_words_done", 64'(words_done), 64'd4);
    checkOutput("wrap_mem_0", 64'(memRead(32'h0)), 64'(vals[2]));
    checkOutput("wrap_mem_1", 64'(memRead(32'h1)), 64'(vals[3]));
    checkOutput("wrap_traffic", 64'({reads[15:0], writes[15:0]}), {32'd0, 16'd4, 16'd4});
    clearMon();
    for (int i = 0; i < 6; i++) sb_q.push_back('{32'h700 + i, 32'h5A5A_A5A5, 4'hF});
    applyStimulus(MODE_FILL, 32'h0, 32'h700, 16'd6, 32'h5A5A_A5A5, 4'hF);
    waitEnd(300, "rfill_end_seen");
    checkOutput("rfill_done", 64'({done_cnt[7:0], err_cnt[7:0]}), 64'h0100);
    checkOutput("rfill_rd_cycles", 64'(rd_cycles), 64'd0);
    spur_en = 0;
    rand_lat = 0;
    repeat (2) @(negedge clk);
    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Initiator-side engine for the block-memory read/write port (rd_addr/rd_en/rd_data/rd_valid, wr_addr/wr_data/wr_bsel/wr_en/wr_ack).
- Accepts one command at a time: either copy LEN words from SRC to DST, or fill LEN words at DST with a constant.
- Sits between control logic or a CPU and a memories instance. It is the master that drives the memory responder's request ports.
- Provides per-request timeout, abort, and progress reporting.

Parameters:
ADDR_W, 32, address width; addresses are word addresses and wrap modulo 2^ADDR_W
DATA_W, 32, data width; wr_bsel width is DATA_W/8
LEN_W, 16, width of the command length and progress counter
TIMEOUT, 255, maximum cycles to wait for rd_valid or wr_ack per request; 0 disables the timeout

Ports:
clk  in  1  single clock, rising edge
arst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; a command is accepted when cmd_valid && cmd_ready
cmd_mode  in  1  0 = copy, 1 = fill
cmd_src  in  ADDR_W  copy source base address
cmd_dst  in  ADDR_W  destination base address
cmd_len  in  LEN_W  number of words
cmd_fill  in  DATA_W  fill pattern
cmd_bsel  in  DATA_W/8  byte select for fill mode; copy mode always uses all ones
abort  in  1  cancel the command in flight
busy  out  1  command in progress
done  out  1  one-cycle pulse on successful completion
error  out  1  one-cycle pulse on timeout or abort
err_code  out  2  1 = timeout, 2 = abort; held until the next command is accepted
words_done  out  LEN_W  count of words completed in the current/last command
rd_addr  out  ADDR_W  read address
rd_en  out  1  read request (level)
rd_data  in  DATA_W  read data, valid when rd_valid is high
rd_valid  in  1  read response
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
wr_bsel  out  DATA_W/8  write byte select
wr_en  out  1  write request (level)
wr_ack  in  1  write response

Behaviour:
- Reset (arst_n low, asynchronous): state IDLE. All outputs are 0 except cmd_ready=1. This includes rd_en, wr_en, busy, done, error, err_code, words_done, all addresses and data.
- Handshake rule: rd_en and rd_addr are held stable until the cycle rd_valid is sampled high. wr_en, wr_addr, wr_data and wr_bsel are held stable until wr_ack is sampled high. rd_valid or wr_ack arriving while the matching enable is low is ignored.
- FSM states: IDLE, RD, WR. All outputs are registered.
- IDLE:
  - A command accepted at cycle T latches src, dst, len, mode, fill and bsel, clears words_done and err_code, and sets busy=1 and cmd_ready=0 at T+1.
  - If len=0: no memory transactions. busy stays 0, cmd_ready stays 1, and done pulses at T+1.
  - Copy mode: enter RD with rd_en=1, rd_addr=src at T+1.
  - Fill mode: enter WR with wr_en=1, wr_addr=dst, wr_data=fill, wr_bsel=bsel at T+1.
- RD: when rd_valid is high at cycle R:
  - rd_data is captured.
  - At R+1: rd_en=0, wr_en=1, wr_data=captured data, wr_bsel=all ones, wr_addr=current dst.
- WR: when wr_ack is high at cycle W:
  - words_done increments at W+1. src and dst each increment by 1, wrapping modulo 2^ADDR_W.
  - If words_done+1 == len: at W+1, wr_en=0, busy=0, cmd_ready=1, done=1 for one cycle, state IDLE.
  - Otherwise at W+1, wr_en=0. Copy mode: rd_en=1 at the next src. Fill mode: wr_en stays 1 with wr_addr advanced (back-to-back writes).
- Throughput: copy mode achieves one word per 2 handshakes with zero idle cycles; fill mode one word per wr_ack.
- Timeout:
  - A wait counter resets each time a request is issued and increments every cycle the request is outstanding.
  - When it reaches TIMEOUT without a response: the enable drops next cycle, error=1 pulse, err_code=1, busy=0, IDLE.
  - words_done reflects the words completed so far.
- Abort while busy:
  - Next cycle: enables low, error pulse, err_code=2, IDLE.
  - If abort and the response (rd_valid/wr_ack) arrive in the same cycle, the response is honoured first. A completed write increments words_done; if that write was the last word, done wins and no error is raised.
  - Abort in IDLE has no effect.
- cmd_valid while busy is not accepted (cmd_ready=0); command inputs are don't-care then.
- Asynchronous reset mid-transfer: immediately returns to the reset values; no partial-state recovery.

Decomposition:
- Package mem_dma_pkg holds:
  - the state enum (IDLE, RD, WR);
  - the err_code constants ERR_NONE=0, ERR_TIMEOUT=1, ERR_ABORT=2;
  - the mode constants MODE_COPY=0, MODE_FILL=1.
- One sub-module, mem_dma_watchdog: a loadable cycle counter with clear, enable, and an expired output, parameterised by TIMEOUT (0 means expired is never asserted).

Test Plan:
- Memory stub with a 2-cycle rd_valid and 1-cycle wr_ack latency. Preload mem[0x10..0x13]=A0..A3; copy src=0x10 dst=0x40 len=4 -> mem[0x40..0x43]=A0..A3, exactly 4 reads and 4 writes, wr_bsel=0xF, done pulse once, words_done=4.
- Fill dst=0x80 len=3 fill=0xDEADBEEF bsel=0x5 -> writes only, wr_bsel=0x5 on all three, no rd_en ever, done after the 3rd wr_ack.
- cmd_len=0 -> done at T+1, no rd_en/wr_en, busy never high.
- Stub never asserts wr_ack, TIMEOUT=8 -> error pulse 8 cycles after wr_en rises, err_code=1, wr_en low next cycle, words_done=0.
- Copy len=5, abort asserted in the same cycle as the 3rd wr_ack -> words_done=3, error with err_code=2, no done; then a new command is accepted normally.
- Randomised stub latencies (0-6 cycles) plus spurious rd_valid/wr_ack while idle, with dst=0xFFFFFFFE len=4 -> addresses wrap to 0x0/0x1, spurious responses ignored, data matches the reference model.
